// File: rtl/detector_impulsos_multi.sv
// Multi-channel push-button front end: per-channel synchroniser, debounce,
// edge-to-impulse conversion and optional auto-repeat while held.
module detector_impulsos_multi #(
    parameter int unsigned CANALES         = 4,
    parameter int unsigned REBOTE_CICLOS   = 1000,
    parameter int unsigned MODO            = 0,
    parameter int unsigned RETARDO_REPETIR = 50000,
    parameter int unsigned PERIODO_REPETIR = 10000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [CANALES-1:0] botones,
    input  logic               repetir_en,
    output logic [CANALES-1:0] botonesLimpios,
    output logic [CANALES-1:0] impulsos
);

    localparam int unsigned CW      = (REBOTE_CICLOS > 1) ? $clog2(REBOTE_CICLOS) : 1;
    localparam int unsigned REP_MAX = (RETARDO_REPETIR > PERIODO_REPETIR) ?
                                      RETARDO_REPETIR : PERIODO_REPETIR;
    localparam int unsigned RW      = (REP_MAX > 1) ? $clog2(REP_MAX) : 1;

    localparam logic [CW-1:0] CNT_FIN = CW'(REBOTE_CICLOS - 1);
    localparam logic [RW-1:0] RET_FIN = RW'(RETARDO_REPETIR - 1);
    localparam logic [RW-1:0] PER_FIN = RW'(PERIODO_REPETIR - 1);

    localparam logic EN_SUBIDA = (MODO == 0) || (MODO == 2);
    localparam logic EN_BAJADA = (MODO == 1) || (MODO == 2);

    logic [CANALES-1:0] s1_q, s1_d;
    logic [CANALES-1:0] s2_q, s2_d;
    logic [CANALES-1:0] limpio_q, limpio_d;
    logic [CANALES-1:0] imp_q, imp_d;
    // periodo_q: 0 while waiting for the first repeat, 1 once in the periodic phase
    logic [CANALES-1:0] periodo_q, periodo_d;
    logic [CANALES-1:0] disparo_c;
    logic [CW-1:0]      cnt_q [CANALES];
    logic [CW-1:0]      cnt_d [CANALES];
    logic [RW-1:0]      rep_q [CANALES];
    logic [RW-1:0]      rep_d [CANALES];

    // Next-state logic for every channel
    always_comb begin
        s1_d      = botones;
        s2_d      = s1_q;
        limpio_d  = limpio_q;
        imp_d     = '0;
        periodo_d = periodo_q;
        disparo_c = '0;
        cnt_d     = cnt_q;
        rep_d     = rep_q;
        for (int i = 0; i < int'(CANALES); i++) begin
            if (s2_q[i] == limpio_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_FIN) begin
                limpio_d[i] = s2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CW'(1);
            end

            // Repeat only counts while held on both sides of the edge
            if (limpio_q[i] && limpio_d[i] && repetir_en) begin
                if (rep_q[i] == (periodo_q[i] ? PER_FIN : RET_FIN)) begin
                    disparo_c[i] = 1'b1;
                    rep_d[i]     = '0;
                    periodo_d[i] = 1'b1;
                end else begin
                    rep_d[i] = rep_q[i] + RW'(1);
                end
            end else begin
                rep_d[i]     = '0;
                periodo_d[i] = 1'b0;
            end

            imp_d[i] = disparo_c[i]
                     | (limpio_d[i] & ~limpio_q[i] & EN_SUBIDA)
                     | (~limpio_d[i] & limpio_q[i] & EN_BAJADA);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            s1_q      <= '0;
            s2_q      <= '0;
            limpio_q  <= '0;
            imp_q     <= '0;
            periodo_q <= '0;
            for (int i = 0; i < int'(CANALES); i++) begin
                cnt_q[i] <= '0;
                rep_q[i] <= '0;
            end
        end else begin
            s1_q      <= s1_d;
            s2_q      <= s2_d;
            limpio_q  <= limpio_d;
            imp_q     <= imp_d;
            periodo_q <= periodo_d;
            for (int i = 0; i < int'(CANALES); i++) begin
                cnt_q[i] <= cnt_d[i];
                rep_q[i] <= rep_d[i];
            end
        end
    end

    assign botonesLimpios = limpio_q;
    assign impulsos       = imp_q;

endmodule
